// File: rtl/bin_para_bcd_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: FSM states,
// correction constants and the parameter legality check.
package bin_para_bcd_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  localparam logic [3:0] LIMIAR_BCD = 4'd5;
  localparam logic [3:0] AJUSTE_BCD = 4'd3;

  // True when n_dig decimal digits can hold the largest n_bits binary value.
  function automatic logic digitos_suficientes(input int n_bits, input int n_dig);
    longint unsigned potencia;
    longint unsigned maximo;
    potencia = 1;
    for (int i = 0; i < n_dig; i++) potencia = potencia * 10;
    maximo = (longint'(1) << n_bits) - 1;
    return potencia > maximo;
  endfunction

endpackage

// File: rtl/bin_para_bcd_serial_correcao.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module correcao_digito_bcd
  import bin_para_bcd_serial_pkg::*;
(
  input  logic [3:0] digito,
  output logic [3:0] corrigido
);

  // 4-bit wrap is intentional; valid digits never exceed 12 after correction.
  assign corrigido = (digito >= LIMIAR_BCD) ? (digito + AJUSTE_BCD) : digito;

endmodule

// File: rtl/bin_para_bcd_serial.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/ready handshake.
// Handshake: inicio is taken only in OCIOSO; ocupado covers the whole conversion
// including the single-cycle pronto pulse, during which saida_bcd is new.
module bin_para_bcd_serial
  import bin_para_bcd_serial_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int N_DIG  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [N_BITS-1:0]    entrada_bin,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [4*N_DIG-1:0]   saida_bcd
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(N_BITS - 1);
  localparam int BCD_W = 4 * N_DIG;

  if (!digitos_suficientes(N_BITS, N_DIG)) begin : g_param_erro
    $error("bin_para_bcd_serial: N_DIG=%0d too small for N_BITS=%0d", N_DIG, N_BITS);
  end

  estado_t              estado;
  logic [N_BITS-1:0]    bin_reg;
  logic [BCD_W-1:0]     bcd_work;
  logic [BCD_W-1:0]     bcd_corr;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W+N_BITS-1:0] desloc;

  for (genvar d = 0; d < N_DIG; d++) begin : g_dig
    correcao_digito_bcd u_corr (
      .digito    (bcd_work[4*d +: 4]),
      .corrigido (bcd_corr[4*d +: 4])
    );
  end

  // Corrected digits and the binary register shift left as one word; the
  // top bit of the top digit falls off (it is always zero for legal inputs).
  assign desloc = {bcd_corr[BCD_W-2:0], bin_reg, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      saida_bcd <= '0;
      bin_reg   <= '0;
      bcd_work  <= '0;
      cnt       <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (inicio) begin
            bin_reg  <= entrada_bin;
            bcd_work <= '0;
            cnt      <= '0;
            ocupado  <= 1'b1;
            estado   <= DESLOCA;
          end
        end
        DESLOCA: begin
          bcd_work <= desloc[BCD_W+N_BITS-1:N_BITS];
          bin_reg  <= desloc[N_BITS-1:0];
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_ULTIMO) begin
            saida_bcd <= desloc[BCD_W+N_BITS-1:N_BITS];
            pronto    <= 1'b1;
            estado    <= PRONTO;
          end
        end
        PRONTO: begin
          pronto  <= 1'b0;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: begin
          pronto  <= 1'b0;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/bin_para_bcd_serial.md
Name: bin_para_bcd_serial

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts one N_BITS binary value per request over N_BITS shift cycles.
- Applies the >=5 -> +3 correction to every BCD digit before each left shift.
- Feeds the display/output path with a registered, stable BCD result and a start/ready handshake, so one small combinational correction cell per digit replaces a fully unrolled array.

Parameters:
N_BITS, 8, width of binary input; also the number of shift cycles.
N_DIG, 3, number of BCD output digits. Must satisfy 10^N_DIG > 2^N_BITS - 1; an illegal combination is an elaboration error.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
inicio  input  1  start request; sampled only in OCIOSO.
entrada_bin  input  N_BITS  binary value; captured on the accepting edge only.
ocupado  output  1  high from the accepting edge until the end of the PRONTO cycle.
pronto  output  1  one-cycle pulse: saida_bcd holds a new result.
saida_bcd  output  4*N_DIG  packed BCD result; digit 0 is bits [3:0].

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state goes to OCIOSO; ocupado=0, pronto=0, saida_bcd=0.
  - shift register and counter are cleared; an in-progress conversion is discarded and no pronto is issued.
- State OCIOSO:
  - If inicio=1 at an edge (E0): load binary register <= entrada_bin, clear BCD work register and counter, go to DESLOCA; ocupado=1 from E0.
  - If inicio=0: remain in OCIOSO.
- State DESLOCA, one shift per edge E1..E_N_BITS:
  - Each digit of the work register passes through the correction cell (value >=5 -> value+3 mod 16, else unchanged).
  - Then {bcd_work, bin_reg} shifts left by 1; the MSB of bin_reg enters bit 0 of digit 0.
  - Counter increments. On the edge where counter == N_BITS-1 the final shift occurs, saida_bcd <= shifted result, and the state goes to PRONTO.
- State PRONTO: pronto=1 and ocupado=1 for exactly one cycle; the next edge goes to OCIOSO with ocupado=0.
- Latency: pronto is high during the cycle that starts N_BITS edges after E0. Throughput is one conversion per N_BITS+2 cycles.
- saida_bcd changes only at the completion edge and holds its value until the next completion or reset. Intermediate work values are never visible.
- inicio while ocupado=1 (DESLOCA or PRONTO) is ignored; it is not queued.
- inicio held high continuously starts a new conversion on the first edge in OCIOSO after PRONTO.
- entrada_bin changes after E0 have no effect on the current conversion.
- Correction arithmetic is 4 bits per digit with the carry discarded. Valid BCD digits (0..9) never exceed 12 after correction, so no overflow occurs within a digit.
- Maximum input 2^N_BITS-1 always fits by the parameter rule.

Decomposition:
- Shared package: state encoding (OCIOSO, DESLOCA, PRONTO) and the correction constants LIMIAR_BCD=4'd5 and AJUSTE_BCD=4'd3.
- The counter width is clog2(N_BITS), derived locally.
- One sub-module, correcao_digito_bcd:
  - 4-bit combinational input/output; +3 when the input is >=5.
  - Instantiated N_DIG times in a generate loop.
- FSM, counter and shift registers stay in the top module.

Test Plan:
1. Reset, then inicio=1 with entrada_bin=8'd255 -> pronto exactly 8 edges after acceptance, saida_bcd=12'h255, ocupado low on the following cycle.
2. Convert 0, 9, 10, 99, 100, 128 -> saida_bcd = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128; exactly one pronto pulse each.
3. Pulse inicio every cycle during a conversion of 8'd37 with entrada_bin toggling -> a single result 12'h037; the next conversion starts only after returning to OCIOSO.
4. Assert rst asynchronously at shift cycle 4 while converting 8'd200 -> outputs go to 0 immediately without waiting for an edge, no pronto; a subsequent conversion of 8'd200 yields 12'h200.
5. Hold inicio=1 continuously with entrada_bin=8'd64 -> pronto every 10 cycles, saida_bcd=12'h064, stable between pulses.
6. Parameter sweep N_BITS=4/N_DIG=2 over all 16 inputs, and N_BITS=10/N_DIG=4 over 0..1023 -> every result matches a reference decimal model; N_BITS=10/N_DIG=3 fails elaboration.
